// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: prio only breaks ties between simultaneous requests.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] pick,
    output logic       any
);

    // One-hot winner; a lone request always wins regardless of prio
    always_comb begin
        pick = req;
        if (req == 2'b11) begin
            pick = prio ? 2'b10 : 2'b01;
        end
    end

    assign any = |req;

endmodule

// File: rtl/mem_arbiter.sv
// Serialises two requesters onto one single-ported memory, one transaction
// at a time, with a fixed IDLE/DONE -> ACCESS -> WAIT x MEM_LAT -> DONE flow.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [31:0]       addr0,
    input  logic [31:0]       addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic              mem_W,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    arb_state_e        state_q, state_d;
    logic              prio_q, prio_d;
    logic              port_q, port_d;
    logic              we_q, we_d;
    logic              oor_q, oor_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [1:0]        pick;
    logic              any_req;
    logic              sel_we;
    logic [31:0]       sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rr_arb2 u_rr (
        .req  ({req1, req0}),
        .prio (prio_q),
        .pick (pick),
        .any  (any_req)
    );

    // Winner's request fields, muxed by the one-hot pick
    always_comb begin
        sel_we    = (pick[0] & we0) | (pick[1] & we1);
        sel_addr  = ({32{pick[0]}} & addr0) | ({32{pick[1]}} & addr1);
        sel_wdata = ({DATA_W{pick[0]}} & wdata0) | ({DATA_W{pick[1]}} & wdata1);
    end

    // Next-state: arbitrate in IDLE/DONE, then a fixed-length access sequence
    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        port_d      = port_q;
        we_d        = we_q;
        oor_d       = oor_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE, DONE: begin
                if (any_req) begin
                    state_d     = ACCESS;
                    port_d      = pick[1];
                    prio_d      = ~pick[1];
                    we_d        = sel_we;
                    oor_d       = |sel_addr[31:ADDR_W];
                    mem_addr_d  = sel_addr[ADDR_W-1:0];
                    mem_wdata_d = sel_wdata;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    // writes and rejected addresses return zero data
                    rdata_d = (we_q || oor_q) ? '0 : mem_rdata;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latched-transaction registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            prio_q      <= 1'b0;
            port_q      <= 1'b0;
            we_q        <= 1'b0;
            oor_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            port_q      <= port_d;
            we_q        <= we_d;
            oor_q       <= oor_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            cnt_q       <= cnt_d;
        end
    end

    // Outputs decode from state and latched fields only, never from req*
    always_comb begin
        gnt0      = (state_q == ACCESS) & ~port_q;
        gnt1      = (state_q == ACCESS) &  port_q;
        done0     = (state_q == DONE) & ~port_q;
        done1     = (state_q == DONE) &  port_q;
        err0      = done0 & oor_q;
        err1      = done1 & oor_q;
        rdata0    = done0 ? rdata_q : '0;
        rdata1    = done1 ? rdata_q : '0;
        mem_W     = (state_q == ACCESS) & we_q & ~oor_q;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter that shares the single-ported 32-word data memory between two requesters, e.g. core0 and a loader/DMA or a second core. It sits between the requesters and the `memory` instance, owning that memory's `W`, address and write-data inputs. It serialises one transaction at a time and returns a per-port completion pulse with read data or an error flag.

## Interface
- `DATA_W`, 32: data width.
- `ADDR_W`, 5: memory word-address width; memory depth is 2**ADDR_W.
- `MEM_LAT`, 1: memory read latency in cycles, counted from the access cycle to valid `mem_rdata`; must be ≥1.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req0`, `req1` in 1: request valid per port.
- `we0`, `we1` in 1: 1 = write, 0 = read.
- `addr0`, `addr1` in 32: word address; only bits [ADDR_W-1:0] index memory.
- `wdata0`, `wdata1` in DATA_W: write data.
- `gnt0`, `gnt1` out 1: one-cycle pulse; request accepted.
- `done0`, `done1` out 1: one-cycle pulse; transaction complete.
- `rdata0`, `rdata1` out DATA_W: read data, valid when `doneN` is high.
- `err0`, `err1` out 1: valid with `doneN`; address out of range.
- `mem_W` out 1: memory write enable.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_rdata` in DATA_W: memory read data.

## Operation
- FSM states: IDLE, ACCESS, WAIT, DONE.
- Arbitration:
  - Arbitration happens only in IDLE and DONE.
  - If any `reqN` is high, the winner is latched: port, we, addr, wdata.
  - Next state is ACCESS.
  - If no request is high, DONE goes to IDLE and IDLE stays in IDLE.
- Round-robin:
  - `prio` register, reset value 0.
  - On simultaneous requests, the `prio` port wins.
  - A single request wins regardless of `prio`.
  - After every grant, `prio` points to the other port.
- ACCESS, exactly one cycle:
  - `gntN` is high for the latched port.
  - Memory is driven from the latched fields.
  - `mem_W` = latched we, unless the address is out of range.
- Out of range means `addr[31:ADDR_W]` ≠ 0. For such a request:
  - `mem_W` is forced 0 and the memory is not written.
  - `err` is set at DONE and `rdata` = 0.
  - Timing is identical to a normal transaction.
- WAIT:
  - Counter runs MEM_LAT cycles.
  - On the last WAIT cycle, `mem_rdata` is captured into the response register for reads.
  - Writes also pass through WAIT, so latency is uniform.
- DONE, one cycle:
  - `doneN` is high for the latched port.
  - `rdataN` and `errN` are driven.
  - The non-selected port's `rdata`/`err` read 0.
- Requester rules:
  - Hold `req`/`we`/`addr`/`wdata` stable until `gnt` is seen.
  - Drop or replace `req` before the next arbitration point (DONE).
  - A `req` still high in DONE is treated as a new request.
- Reset:
  - Asynchronous; takes effect immediately, including mid-transaction.
  - State → IDLE, `prio` → 0.
  - All outputs 0: `gnt*`, `done*`, `err*`, `rdata*`, `mem_W`, `mem_addr`, `mem_wdata`.
  - An in-flight write aborts because `mem_W` drops immediately.
  - No `done` is issued for the aborted transaction.

## Timing
- Request sampled at the edge ending cycle N (IDLE or DONE).
- Cycle N+1: ACCESS, with `gnt` and the memory drive.
- Cycles N+2 … N+1+MEM_LAT: WAIT.
- Cycle N+2+MEM_LAT: DONE. With MEM_LAT=1, `done` comes 3 cycles after sampling.
- Back-to-back throughput: one transaction per 2+MEM_LAT cycles, since DONE re-arbitrates.
- Outside ACCESS:
  - `mem_W` = 0.
  - `mem_addr` and `mem_wdata` hold their last values; they are don't-care to memory.
- All outputs are registered or decoded from state only; there is no combinational path from `req*` to any output.

## Structure
- Shared header/package `mem_arb_pkg`: state encodings (IDLE=2'd0, ACCESS=2'd1, WAIT=2'd2, DONE=2'd3), plus the default DATA_W and ADDR_W values reused by `top`.
- Sub-module `rr_arb2`:
  - Inputs: `req[1:0]`, `prio`.
  - Outputs: one-hot `pick[1:0]`, `any`.
  - Purely combinational; `prio` is updated in `mem_arbiter`.
- `top` instantiates `mem_arbiter` between `proc` and `memory`, with `clk` and `reset` shared.

## Test plan
- Single read: preload mem[5]=0xDEADBEEF; `req0` read addr 5 at N → `gnt0` at N+1, `done0` at N+3 with `rdata0`=0xDEADBEEF, `err0`=0.
- Write then read: port1 writes 0x12345678 to addr 31, then reads addr 31 → `mem_W` high only in the write's ACCESS cycle; read returns 0x12345678.
- Contention: `req0` and `req1` both held continuously after reset → grants alternate 0,1,0,1 with `gnt` spacing of 3 cycles.
- Out of range: `req0` write addr 0x20, data 0xFFFFFFFF → `mem_W` stays 0, `done0`+`err0` at N+3, `rdata0`=0, mem[0] unchanged.
- Reset mid-op: assert `reset` during ACCESS of a write to addr 3 → `mem_W` falls the same cycle, mem[3] unchanged, no `done`, and the next simultaneous request goes to port 0.
- MEM_LAT=3 build: read → `done` at N+5 with correct data.
